// File: rtl/button_input.sv
// Conditions raw active-low buttons into debounced levels plus press/release/event pulses.
// Optional auto-repeat on held buttons is enabled by defining BUTTON_INPUT_AUTO_REPEAT_EN.
module button_input #(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 16000,
    parameter int REPEAT_DELAY    = 4000000,
    parameter int REPEAT_PERIOD   = 1600000,
    parameter int CNT_W           = 23
) (
    input  logic                 _i_clk,
    input  logic                 _i_rst,
    input  logic [N_BTN-1:0]     _i_btn,
    output logic [3*N_BTN-1:0]   __output
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef BUTTON_INPUT_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY,
        RPT_REPEAT
    } rpt_state_t;
`endif

    logic [N_BTN-1:0] sync_a;
    logic [N_BTN-1:0] sync_b;
    logic [N_BTN-1:0] level_v;
    logic [N_BTN-1:0] event_v;
    logic [N_BTN-1:0] release_v;

    // Inversion happens before the synchroniser so everything downstream sees 1 = pressed.
    always_ff @(posedge _i_clk) begin
        if (_i_rst) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= ~_i_btn;
            sync_b <= sync_a;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        logic [CNT_W-1:0] db_cnt;
        logic [CNT_W-1:0] db_cnt_nxt;
        logic             level;
        logic             level_nxt;
        logic             rise;
        logic             fall;
        logic             rpt_fire;
        logic             evt;
        logic             rel;

        always_comb begin
            level_nxt  = level;
            db_cnt_nxt = '0;
            if (sync_b[i] != level) begin
                if (db_cnt == DB_LAST) begin
                    level_nxt = sync_b[i];
                end else begin
                    db_cnt_nxt = db_cnt + 1'b1;
                end
            end
        end

        assign rise = level_nxt & ~level;
        assign fall = level & ~level_nxt;

`ifdef BUTTON_INPUT_AUTO_REPEAT_EN
        rpt_state_t       state;
        rpt_state_t       state_nxt;
        logic [CNT_W-1:0] rpt_cnt;
        logic [CNT_W-1:0] rpt_cnt_nxt;

        always_ff @(posedge _i_clk) begin
            if (_i_rst) begin
                state   <= RPT_IDLE;
                rpt_cnt <= '0;
            end else begin
                state   <= state_nxt;
                rpt_cnt <= rpt_cnt_nxt;
            end
        end

        // Looking at level_nxt lets a release abort the FSM on the very edge the release pulse fires.
        always_comb begin
            state_nxt   = state;
            rpt_cnt_nxt = rpt_cnt;
            rpt_fire    = 1'b0;
            if (!level_nxt) begin
                state_nxt   = RPT_IDLE;
                rpt_cnt_nxt = '0;
            end else begin
                case (state)
                    RPT_IDLE: begin
                        if (rise) begin
                            state_nxt   = RPT_DELAY;
                            rpt_cnt_nxt = '0;
                        end
                    end
                    RPT_DELAY: begin
                        if (rpt_cnt == RD_LAST) begin
                            rpt_fire    = 1'b1;
                            rpt_cnt_nxt = '0;
                            state_nxt   = RPT_REPEAT;
                        end else begin
                            rpt_cnt_nxt = rpt_cnt + 1'b1;
                        end
                    end
                    RPT_REPEAT: begin
                        if (rpt_cnt == RP_LAST) begin
                            rpt_fire    = 1'b1;
                            rpt_cnt_nxt = '0;
                        end else begin
                            rpt_cnt_nxt = rpt_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state_nxt   = RPT_IDLE;
                        rpt_cnt_nxt = '0;
                    end
                endcase
            end
        end
`else
        assign rpt_fire = 1'b0;
`endif

        // Pulses are registered alongside level so they line up with the level transition.
        always_ff @(posedge _i_clk) begin
            if (_i_rst) begin
                db_cnt <= '0;
                level  <= 1'b0;
                evt    <= 1'b0;
                rel    <= 1'b0;
            end else begin
                db_cnt <= db_cnt_nxt;
                level  <= level_nxt;
                evt    <= rise | rpt_fire;
                rel    <= fall;
            end
        end

        assign level_v[i]   = level;
        assign event_v[i]   = evt;
        assign release_v[i] = rel;
    end

    assign __output = {release_v, event_v, level_v};

endmodule

// File: tb/tb_button_input.sv
// Directed bench for button_input with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
// Expected repeat events depend on whether BUTTON_INPUT_AUTO_REPEAT_EN is defined for the build.
module tb_button_input;

    localparam int N_BTN           = 4;
    localparam int DEBOUNCE_CYCLES = 4;
    localparam int REPEAT_DELAY    = 10;
    localparam int REPEAT_PERIOD   = 3;
    localparam int CNT_W           = 8;

`ifdef BUTTON_INPUT_AUTO_REPEAT_EN
    localparam bit RPT_EN = 1'b1;
`else
    localparam bit RPT_EN = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic [N_BTN-1:0]  btn;
    logic [3*N_BTN-1:0] dout;

    int n_checks;
    int n_fail;

    button_input #(
        .N_BTN(N_BTN),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD),
        .CNT_W(CNT_W)
    ) dut (
        ._i_clk(clk),
        ._i_rst(rst),
        ._i_btn(btn),
        .__output(dout)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [11:0] exp;
        rst = 1'b1;
        btn = 4'hF;
        exp = 12'h000;
        for (int k = 1; k <= 3; k++) begin
            step();
            n_checks++;
            if (dout !== exp) begin
                n_fail++;
                $display("[TB] FAIL reset_hold cyc %0d: got %h expected %h", k, dout, exp);
            end
        end
        rst = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            n_checks++;
            if (dout !== exp) begin
                n_fail++;
                $display("[TB] FAIL reset_idle cyc %0d: got %h expected %h", k, dout, exp);
            end
        end
    endtask

    task automatic test_press_release();
        logic [11:0] exp;
        btn = 4'b1110;
        for (int k = 1; k <= 6; k++) begin
            step();
            exp = (k == 6) ? 12'h011 : 12'h000;
            n_checks++;
            if (dout !== exp) begin
                n_fail++;
                $display("[TB] FAIL press0 edge %0d: got %h expected %h", k, dout, exp);
            end
        end
        btn = 4'b1111;
        for (int k = 1; k <= 7; k++) begin
            step();
            exp = (k == 6) ? 12'h100 : ((k == 7) ? 12'h000 : 12'h001);
            n_checks++;
            if (dout !== exp) begin
                n_fail++;
                $display("[TB] FAIL release0 edge %0d: got %h expected %h", k, dout, exp);
            end
        end
    endtask

    task automatic test_glitch();
        logic [11:0] exp;
        exp = 12'h000;
        btn = 4'b1101;
        for (int k = 1; k <= 3; k++) begin
            step();
            n_checks++;
            if (dout !== exp) begin
                n_fail++;
                $display("[TB] FAIL glitch_low cyc %0d: got %h expected %h", k, dout, exp);
            end
        end
        btn = 4'b1111;
        for (int k = 1; k <= 10; k++) begin
            step();
            n_checks++;
            if (dout !== exp) begin
                n_fail++;
                $display("[TB] FAIL glitch_after cyc %0d: got %h expected %h", k, dout, exp);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [11:0] exp;
        btn = 4'b0011;
        for (int k = 1; k <= 6; k++) begin
            step();
            exp = (k == 6) ? 12'h0CC : 12'h000;
            n_checks++;
            if (dout !== exp) begin
                n_fail++;
                $display("[TB] FAIL press23 edge %0d: got %h expected %h", k, dout, exp);
            end
        end
        btn = 4'b1111;
        for (int k = 1; k <= 7; k++) begin
            step();
            exp = (k == 6) ? 12'hC00 : ((k == 7) ? 12'h000 : 12'h00C);
            n_checks++;
            if (dout !== exp) begin
                n_fail++;
                $display("[TB] FAIL release23 edge %0d: got %h expected %h", k, dout, exp);
            end
        end
    endtask

    // Level rises at t=0; release is first sampled at t=30, so level falls at t=35.
    task automatic test_auto_repeat();
        logic [11:0] exp;
        logic        lev;
        logic        ev;
        logic        rel;
        btn = 4'b1110;
        for (int k = 1; k <= 6; k++) begin
            step();
            exp = (k == 6) ? 12'h011 : 12'h000;
            n_checks++;
            if (dout !== exp) begin
                n_fail++;
                $display("[TB] FAIL rpt_press edge %0d: got %h expected %h", k, dout, exp);
            end
        end
        for (int t = 1; t <= 40; t++) begin
            if (t == 30) btn = 4'b1111;
            step();
            lev = (t < 35);
            rel = (t == 35);
            ev  = RPT_EN && lev && (t >= REPEAT_DELAY) &&
                  (((t - REPEAT_DELAY) % REPEAT_PERIOD) == 0);
            exp = {3'b000, rel, 3'b000, ev, 3'b000, lev};
            n_checks++;
            if (dout !== exp) begin
                n_fail++;
                $display("[TB] FAIL repeat t=+%0d: got %h expected %h", t, dout, exp);
            end
        end
    endtask

    task automatic test_reset_mid_debounce();
        logic [11:0] exp;
        btn = 4'b1110;
        for (int k = 1; k <= 4; k++) begin
            step();
            exp = 12'h000;
            n_checks++;
            if (dout !== exp) begin
                n_fail++;
                $display("[TB] FAIL mid_pre edge %0d: got %h expected %h", k, dout, exp);
            end
        end
        rst = 1'b1;
        step();
        exp = 12'h000;
        n_checks++;
        if (dout !== exp) begin
            n_fail++;
            $display("[TB] FAIL mid_in_reset: got %h expected %h", dout, exp);
        end
        rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            exp = (k == 6) ? 12'h011 : 12'h000;
            n_checks++;
            if (dout !== exp) begin
                n_fail++;
                $display("[TB] FAIL mid_repress edge %0d: got %h expected %h", k, dout, exp);
            end
        end
        btn = 4'b1111;
        for (int k = 1; k <= 7; k++) begin
            step();
            exp = (k == 6) ? 12'h100 : ((k == 7) ? 12'h000 : 12'h001);
            n_checks++;
            if (dout !== exp) begin
                n_fail++;
                $display("[TB] FAIL mid_release edge %0d: got %h expected %h", k, dout, exp);
            end
        end
    endtask

    initial begin
        clk      = 1'b0;
        rst      = 1'b1;
        btn      = 4'hF;
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_press_release();
        test_glitch();
        test_simultaneous();
        test_auto_repeat();
        test_reset_mid_debounce();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
